// File: rtl/contador_regressivo_pkg.sv
// rtl/contador_regressivo_pkg.sv - shared state encodings and defaults for the down counter/timer
package contador_regressivo_pkg;

  localparam int N_PADRAO    = 4;
  localparam int MEIO_PADRAO = 7;

  // Encodings are also decoded by the control unit, so keep them fixed.
  typedef enum logic [1:0] {
    PARADO   = 2'b00,
    CONTANDO = 2'b01,
    FIM      = 2'b10
  } estado_t;

endpackage

// File: rtl/contador_regressivo_if.sv
// rtl/contador_regressivo_if.sv - control/status bundle between control unit and down counter
interface contador_regressivo_if
  import contador_regressivo_pkg::*;
#(
  parameter int N = N_PADRAO
);

  logic         clr;
  logic         ld;
  logic         ent;
  logic         enp;
  logic [N-1:0] D;
  logic [N-1:0] Q;
  logic         rco;
  logic         meio;
  logic         fim;
  logic         contando;

  modport master (
    output clr, ld, ent, enp, D,
    input  Q, rco, meio, fim, contando
  );

  modport slave (
    input  clr, ld, ent, enp, D,
    output Q, rco, meio, fim, contando
  );

endinterface

// File: rtl/contador_regressivo_dec.sv
// rtl/contador_regressivo_dec.sv - combinational status decode (rco, meio, contando)
module contador_regressivo_dec
  import contador_regressivo_pkg::*;
#(
  parameter int N    = N_PADRAO,
  parameter int MEIO = MEIO_PADRAO
) (
  input  logic [N-1:0] q,
  input  logic         ent,
  input  estado_t      estado,
  output logic         rco,
  output logic         meio,
  output logic         contando
);

  localparam logic [N-1:0] MEIO_Q = N'(MEIO);

  assign rco      = ent && (q == '0);
  assign meio     = (q == MEIO_Q);
  assign contando = (estado == CONTANDO);

endmodule

// File: rtl/contador_regressivo.sv
// rtl/contador_regressivo.sv - loadable down counter/timer; CONTADOR_REGRESSIVO_RELOAD_EN adds auto-reload
module contador_regressivo
  import contador_regressivo_pkg::*;
#(
  parameter int N    = N_PADRAO,
  parameter int MEIO = MEIO_PADRAO
) (
  input  logic                 clock,
  input  logic                 reset,
  contador_regressivo_if.slave bus
);

  localparam logic [N-1:0] UM = N'(1);

  estado_t      estado;
  logic [N-1:0] q;
  logic         fim;
  logic         conta;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
  logic [N-1:0] r;
`endif

  assign conta = bus.ent && bus.enp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= PARADO;
      q      <= '0;
      fim    <= 1'b0;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
      r      <= '0;
`endif
    end else begin
      fim <= 1'b0;
      if (!bus.clr) begin
        q      <= '0;
        estado <= PARADO;
      end else if (!bus.ld) begin
        q <= bus.D;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
        r <= bus.D;
`endif
        if (bus.D != '0) begin
          estado <= CONTANDO;
        end else begin
          estado <= FIM;
          fim    <= 1'b1;
        end
      end else begin
        case (estado)
          PARADO: begin
          end
          CONTANDO: begin
            // q <= 1 also catches a stray zero so the count can never wrap.
            if (conta) begin
              if (q <= UM) begin
                q      <= '0;
                estado <= FIM;
                fim    <= 1'b1;
              end else begin
                q <= q - UM;
              end
            end
          end
          FIM: begin
            q <= '0;
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
            if (conta && (r != '0)) begin
              q      <= r;
              estado <= CONTANDO;
            end
`endif
          end
          default: estado <= PARADO;
        endcase
      end
    end
  end

  assign bus.Q   = q;
  assign bus.fim = fim;

  contador_regressivo_dec #(
    .N    (N),
    .MEIO (MEIO)
  ) u_dec (
    .q        (q),
    .ent      (bus.ent),
    .estado   (estado),
    .rco      (bus.rco),
    .meio     (bus.meio),
    .contando (bus.contando)
  );

endmodule

// File: tb/tb_contador_regressivo.sv
// tb/tb_contador_regressivo.sv - scoreboard bench for the down counter/timer
module tb_contador_regressivo;

  typedef logic [7:0] vec_t;

  logic clock;
  logic reset;
  vec_t sb[$];
  int   n_cmp;
  int   n_err;

  contador_regressivo_if #(.N(4)) bus ();

  contador_regressivo #(.N(4), .MEIO(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {Q, fim, rco, meio, contando} decoded from the required behaviour.
  function automatic vec_t esperado(int q, bit f, bit c, bit e);
    logic [3:0] qq;
    qq = 4'(q);
    return {qq, f, e && (qq == 4'd0), (qq == 4'd7), c};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    vec_t got, want;
    reset = 1'b1;
    bus.clr = 1'b1; bus.ld = 1'b1; bus.ent = 1'b0; bus.enp = 1'b0; bus.D = 4'd0;
    sb.push_back(esperado(0, 0, 0, 0));
    repeat (2) @(posedge clock);
    #1;
    got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_inicial: got %b expected %b (Q,fim,rco,meio,contando)", got, want); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld  = (i == 0) ? 1'b0 : 1'b1;
      bus.D   = 4'd7;
      bus.ent = (i == 1); bus.enp = (i == 1);
      sb.push_back(esperado(7 - i, 0, 1, i == 1));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL reset_preparo[%0d]: got %b expected %b", i, got, want); end
    end
    #2 reset = 1'b1;
    sb.push_back(esperado(0, 0, 0, 1));
    #1;
    got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_assincrono: got %b expected %b", got, want); end
    bus.ent = 1'b0; bus.enp = 1'b0;
    #1 reset = 1'b0;
  endtask

  task automatic test_count5();
    vec_t got, want;
    bus.ld = 1'b0; bus.D = 4'd5; bus.ent = 1'b0; bus.enp = 1'b0;
    sb.push_back(esperado(5, 0, 1, 0));
    tick();
    got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL count5_carga: got %b expected %b", got, want); end
    bus.ld = 1'b1; bus.ent = 1'b1; bus.enp = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      sb.push_back(esperado(i, i == 0, i != 0, 1));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL count5[%0d]: got %b expected %b", i, got, want); end
    end
    for (int i = 0; i < 2; i++) begin
      bus.enp = 1'b0; bus.ent = (i == 0);
      sb.push_back(esperado(0, 0, 0, i == 0));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL count5_pos_fim[%0d]: got %b expected %b", i, got, want); end
    end
  endtask

  task automatic test_meio();
    vec_t got, want;
    bus.ld = 1'b0; bus.D = 4'd15; bus.ent = 1'b0; bus.enp = 1'b0;
    sb.push_back(esperado(15, 0, 1, 0));
    tick();
    got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL meio_carga: got %b expected %b", got, want); end
    bus.ld = 1'b1; bus.ent = 1'b1; bus.enp = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      sb.push_back(esperado(i, i == 0, i != 0, 1));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL meio[%0d]: got %b expected %b", i, got, want); end
    end
    bus.ent = 1'b0;
    sb.push_back(esperado(0, 0, 0, 0));
    tick();
    got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL meio_rco_ent0: got %b expected %b", got, want); end
    bus.enp = 1'b0;
  endtask

  task automatic test_priority();
    vec_t got, want;
    logic [3:0] d_tab [5] = '{4'd7, 4'd7, 4'd9, 4'd4, 4'd4};
    bit         ld_tab[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit         cl_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int         q_tab [5] = '{7, 6, 9, 0, 0};
    bit         c_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.clr = cl_tab[i]; bus.ld = ld_tab[i]; bus.D = d_tab[i];
      bus.ent = (i != 0); bus.enp = (i != 0);
      sb.push_back(esperado(q_tab[i], 0, c_tab[i], i != 0));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL prioridade[%0d]: got %b expected %b", i, got, want); end
    end
    bus.clr = 1'b1; bus.ld = 1'b1; bus.ent = 1'b0; bus.enp = 1'b0;
  endtask

  task automatic test_hold();
    vec_t got, want;
    bus.ld = 1'b0; bus.D = 4'd5;
    sb.push_back(esperado(5, 0, 1, 0));
    tick();
    got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL hold_carga: got %b expected %b", got, want); end
    bus.ld = 1'b1; bus.ent = 1'b1;
    for (int i = 0; i < 9; i++) begin
      // edges 0-1 count, 2-5 paused by enp, 6-8 count to zero
      bus.enp = !(i >= 2 && i <= 5);
      sb.push_back(esperado((i < 2) ? 4 - i : (i <= 5) ? 3 : 8 - i, i == 8, i != 8, 1));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL hold[%0d]: got %b expected %b", i, got, want); end
    end
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
    bus.enp = 1'b0;
`endif
    for (int i = 0; i < 10; i++) begin
      sb.push_back(esperado(0, 0, 0, 1));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL sem_wrap[%0d]: got %b expected %b", i, got, want); end
    end
    bus.ent = 1'b0; bus.enp = 1'b0;
  endtask

  task automatic test_load_zero();
    vec_t got, want;
    for (int i = 0; i < 4; i++) begin
      bus.clr = (i != 0);
      bus.ld  = (i == 3);
      bus.D   = 4'd0;
      sb.push_back(esperado(0, i == 1 || i == 2, 0, 0));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL carga_zero[%0d]: got %b expected %b", i, got, want); end
    end
  endtask

  task automatic test_reload();
    vec_t got, want;
    int   seq[8];
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
    seq = '{2, 1, 0, 3, 2, 1, 0, 3};
`else
    seq = '{2, 1, 0, 0, 0, 0, 0, 0};
`endif
    bus.ld = 1'b0; bus.D = 4'd3;
    sb.push_back(esperado(3, 0, 1, 0));
    tick();
    got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reload_carga: got %b expected %b", got, want); end
    bus.ld = 1'b1; bus.ent = 1'b1; bus.enp = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef CONTADOR_REGRESSIVO_RELOAD_EN
      sb.push_back(esperado(seq[i], seq[i] == 0, seq[i] != 0, 1));
`else
      sb.push_back(esperado(seq[i], i == 2, seq[i] != 0, 1));
`endif
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL reload[%0d]: got %b expected %b", i, got, want); end
    end
    bus.ent = 1'b0; bus.enp = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t got, want;
    logic [3:0] d_tab [5] = '{4'd2, 4'd4, 4'd4, 4'd1, 4'd1};
    bit         ld_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         q_tab [5] = '{2, 4, 3, 1, 0};
    for (int i = 0; i < 5; i++) begin
      bus.ld = ld_tab[i]; bus.D = d_tab[i];
      bus.ent = (i >= 2); bus.enp = (i >= 2);
      sb.push_back(esperado(q_tab[i], i == 4, i != 4, i >= 2));
      tick();
      got = {bus.Q, bus.fim, bus.rco, bus.meio, bus.contando}; want = sb.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, want); end
    end
    bus.ld = 1'b1; bus.ent = 1'b0; bus.enp = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_count5();
    test_meio();
    test_priority();
    test_hold();
    test_load_zero();
    test_reload();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_vazio: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
